// File: rtl/enc_dec_pkg.sv
// rtl/enc_dec_pkg.sv - shared constants, types and helpers for the shift-cipher encrypt/decrypt path
package enc_dec_pkg;

    localparam int ASCII_UA      = 65;
    localparam int ASCII_LA      = 97;
    localparam int ALPHA_N       = 26;
    localparam int EXT_W         = 32;
    localparam int FOLD_W        = 6;
    localparam int LOW_SLOT_BASE = 20;
    localparam int AMT_MOD       = 7;

    typedef logic [EXT_W-1:0] ext_word_t;
    typedef logic [2:0]       amt_t;

    typedef struct packed {
        logic       valid;
        logic       upper;
        logic       lower;
        logic       alpha;
        logic       err;
        logic [4:0] pos;
        logic [7:0] data;
        amt_t       amt;
    } stage1_t;

    // Operands are at most 7 and 6, so a single conditional subtract is enough.
    function automatic amt_t mod7_add(input amt_t a, input amt_t b);
        logic [3:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= 4'(AMT_MOD))
            sum = sum - 4'(AMT_MOD);
        return sum[2:0];
    endfunction

endpackage

// File: rtl/encrypt_pipe_shift_if.sv
// rtl/encrypt_pipe_shift_if.sv - byte-in / extended-word-out bus of the encrypt shift stage
interface encrypt_pipe_shift_if;
    import enc_dec_pkg::*;

    logic       en;
    logic [7:0] din;
    logic       mode;
    logic       shift_en;
    amt_t       shift_amt;
    logic [2:0] rot_freq;

    logic       en_out;
    ext_word_t  ext_out;
    logic       is_upper;
    logic       is_lower;
    amt_t       amt_out;
    logic       amt_err;

    modport master (
        output en, din, mode, shift_en, shift_amt, rot_freq,
        input  en_out, ext_out, is_upper, is_lower, amt_out, amt_err
    );

    modport slave (
        input  en, din, mode, shift_en, shift_amt, rot_freq,
        output en_out, ext_out, is_upper, is_lower, amt_out, amt_err
    );

endinterface

// File: rtl/encrypt_pipe_shift_alpha_slot_enc.sv
// rtl/encrypt_pipe_shift_alpha_slot_enc.sv - classifies an ASCII byte and maps letters to their extended-word slot
module alpha_slot_enc
    import enc_dec_pkg::*;
(
    input  logic [7:0] din,
    output logic       upper,
    output logic       lower,
    output logic [4:0] pos
);

    logic [4:0] p;

    always_comb begin
        upper = (din >= 8'(ASCII_UA)) && (din < 8'(ASCII_UA + ALPHA_N));
        lower = (din >= 8'(ASCII_LA)) && (din < 8'(ASCII_LA + ALPHA_N));
        p     = '0;
        pos   = '0;
        if (upper)
            p = 5'(din - 8'(ASCII_UA));
        else if (lower)
            p = 5'(din - 8'(ASCII_LA));
        // Last six letters fold into the low slots so the shifted bit never leaves the word.
        if (upper || lower) begin
            if (p < 5'(LOW_SLOT_BASE))
                pos = p + 5'(FOLD_W);
            else
                pos = p - 5'(LOW_SLOT_BASE);
        end
    end

endmodule

// File: rtl/encrypt_pipe_shift.sv
// rtl/encrypt_pipe_shift.sv - two-stage encrypt shift stage with rotating per-letter shift amount
module encrypt_pipe_shift
    import enc_dec_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    encrypt_pipe_shift_if.slave  bus
);

    logic       accept;
    logic       upper_c;
    logic       lower_c;
    logic [4:0] pos_c;
    logic       err_c;
    logic       alpha_c;
    amt_t       eff_c;

    logic [2:0] count;
    logic [2:0] count_next;
    amt_t       step;
    amt_t       step_next;

    stage1_t    s1;
    logic [4:0] slot;

    logic       en_out_q;
    ext_word_t  ext_out_q;
    logic       is_upper_q;
    logic       is_lower_q;
    amt_t       amt_out_q;
    logic       amt_err_q;

    alpha_slot_enc u_slot (
        .din   (bus.din),
        .upper (upper_c),
        .lower (lower_c),
        .pos   (pos_c)
    );

    assign accept  = bus.en & ~bus.mode;
    assign err_c   = (bus.shift_amt == 3'd7);
    assign alpha_c = (upper_c | lower_c) & bus.shift_en & ~err_c;
    assign eff_c   = mod7_add(bus.shift_amt, step);

    // Compare with ">=" so a lowered rot_freq wraps on the very next letter.
    always_comb begin
        count_next = count;
        step_next  = step;
        if (accept && alpha_c && (bus.rot_freq != 3'd0)) begin
            if (({1'b0, count} + 4'd1) >= {1'b0, bus.rot_freq}) begin
                count_next = '0;
                step_next  = mod7_add(step, 3'd1);
            end else begin
                count_next = count + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            step  <= '0;
        end else begin
            count <= count_next;
            step  <= step_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= '0;
        end else begin
            s1.valid <= accept;
            s1.upper <= upper_c;
            s1.lower <= lower_c;
            s1.alpha <= alpha_c;
            s1.err   <= err_c;
            s1.pos   <= pos_c;
            s1.data  <= bus.din;
            s1.amt   <= eff_c;
        end
    end

    assign slot = s1.pos + 5'(s1.amt);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_out_q   <= 1'b0;
            ext_out_q  <= '0;
            is_upper_q <= 1'b0;
            is_lower_q <= 1'b0;
            amt_out_q  <= '0;
            amt_err_q  <= 1'b0;
        end else begin
            en_out_q   <= s1.valid;
            is_upper_q <= s1.valid & s1.alpha & s1.upper;
            is_lower_q <= s1.valid & s1.alpha & s1.lower;
            amt_err_q  <= s1.valid & s1.err;
            amt_out_q  <= s1.valid ? s1.amt : '0;
            if (!s1.valid)
                ext_out_q <= '0;
            else if (s1.alpha)
                ext_out_q <= ext_word_t'(1) << slot;
            else
                ext_out_q <= {24'b0, s1.data};
        end
    end

    assign bus.en_out   = en_out_q;
    assign bus.ext_out  = ext_out_q;
    assign bus.is_upper = is_upper_q;
    assign bus.is_lower = is_lower_q;
    assign bus.amt_out  = amt_out_q;
    assign bus.amt_err  = amt_err_q;

endmodule

// File: tb/tb_encrypt_pipe_shift.sv
// tb/tb_encrypt_pipe_shift.sv - randomized and directed self-checking bench for encrypt_pipe_shift
module tb_encrypt_pipe_shift;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    encrypt_pipe_shift_if bif ();

    encrypt_pipe_shift dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [7:0]  din;
        logic        alpha;
        logic        upper;
        logic        lower;
        logic        err;
        logic [31:0] ext;
        logic [2:0]  amt;
        bit          fix;
        logic [31:0] fix_ext;
        logic [2:0]  fix_amt;
    } exp_t;

    exp_t q[$];
    int   m_step  = 0;
    int   m_count = 0;
    bit          fix_on  = 0;
    logic [31:0] fix_ext = '0;
    logic [2:0]  fix_amt = '0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", tag, cyc, got, exp);
        end
    endtask

    // Reverse path as the decrypt stage sees it: undo the shift, locate the bit, unfold the slot.
    function automatic logic [7:0] decrypt(input logic [31:0] ext, input logic [2:0] amt, input logic up);
        logic [31:0] x;
        int b;
        int p;
        x = ext >> amt;
        b = -1;
        for (int i = 0; i < 32; i++)
            if (x[i]) b = i;
        if (b < 0) return 8'hff;
        p = (b >= 6) ? b - 6 : b + 20;
        return 8'((up ? 65 : 97) + p);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            check_val("en_out", {31'b0, bif.en_out}, 32'd1);
            check_val("ext_out", bif.ext_out, e.ext);
            check_val("is_upper", {31'b0, bif.is_upper}, {31'b0, e.upper});
            check_val("is_lower", {31'b0, bif.is_lower}, {31'b0, e.lower});
            check_val("amt_out", {29'b0, bif.amt_out}, {29'b0, e.amt});
            check_val("amt_err", {31'b0, bif.amt_err}, {31'b0, e.err});
            if (e.fix) begin
                check_val("dir_ext", bif.ext_out, e.fix_ext);
                check_val("dir_amt", {29'b0, bif.amt_out}, {29'b0, e.fix_amt});
            end
            if (e.alpha)
                check_val("round_trip", {24'b0, decrypt(bif.ext_out, bif.amt_out, bif.is_upper)}, {24'b0, e.din});
        end else begin
            check_val("idle_en_out", {31'b0, bif.en_out}, 32'd0);
            check_val("idle_ext_out", bif.ext_out, 32'd0);
        end
    end

    task automatic set_fix(input logic [31:0] x, input logic [2:0] a);
        fix_on  = 1;
        fix_ext = x;
        fix_amt = a;
    endtask

    task automatic drive(input logic e, input logic [7:0] d, input logic m, input logic se,
                         input logic [2:0] a, input logic [2:0] rf);
        exp_t x;
        int   p;
        bit   up, lo;
        @(negedge clk);
        #1;
        bif.en = e; bif.din = d; bif.mode = m;
        bif.shift_en = se; bif.shift_amt = a; bif.rot_freq = rf;
        if (e && !m && rst) begin
            up = (d >= 65 && d <= 90);
            lo = (d >= 97 && d <= 122);
            p  = up ? d - 65 : (lo ? d - 97 : 0);
            x.due     = cyc + 2;
            x.din     = d;
            x.err     = (a == 7);
            x.alpha   = (up || lo) && se && (a != 7);
            x.upper   = x.alpha && up;
            x.lower   = x.alpha && lo;
            x.amt     = 3'((a + m_step) % 7);
            x.ext     = x.alpha ? (32'd1 << (((p < 20) ? p + 6 : p - 20) + x.amt)) : {24'b0, d};
            x.fix     = fix_on;
            x.fix_ext = fix_ext;
            x.fix_amt = fix_amt;
            q.push_back(x);
            if (x.alpha && rf != 0) begin
                m_count++;
                if (m_count >= rf) begin
                    m_count = 0;
                    m_step  = (m_step + 1) % 7;
                end
            end
        end
        fix_on = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 8'h00, 0, 1, 3'd0, bif.rot_freq);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 0;
        bif.en = 0;
        q.delete();
        m_step = 0;
        m_count = 0;
        repeat (2) @(negedge clk);
        #1;
        rst = 1;
    endtask

    initial begin
        bif.en = 0; bif.din = 0; bif.mode = 0;
        bif.shift_en = 1; bif.shift_amt = 0; bif.rot_freq = 0;
        repeat (3) @(negedge clk);
        #1 rst = 1;

        set_fix(32'h40, 3'd0);  drive(1, 8'd65, 0, 1, 3'd0, 3'd0);
        set_fix(32'h200, 3'd3); drive(1, 8'd65, 0, 1, 3'd3, 3'd0);
        set_fix(32'h80, 3'd2);  drive(1, 8'd90, 0, 1, 3'd2, 3'd0);
        set_fix(32'h800, 3'd6); drive(1, 8'd122, 0, 1, 3'd6, 3'd0);
        set_fix(32'h35, 3'd2);  drive(1, 8'h35, 0, 1, 3'd2, 3'd0);
        set_fix(32'h71, 3'd4);  drive(1, 8'h71, 0, 0, 3'd4, 3'd0);

        set_fix(32'h80, 3'd1);   drive(1, "a", 0, 1, 3'd1, 3'd2);
        set_fix(32'h100, 3'd1);  drive(1, "b", 0, 1, 3'd1, 3'd2);
        set_fix(32'h400, 3'd2);  drive(1, "c", 0, 1, 3'd1, 3'd2);
        set_fix(32'h37, 3'd2);   drive(1, "7", 0, 1, 3'd1, 3'd2);
        set_fix(32'h800, 3'd2);  drive(1, "d", 0, 1, 3'd1, 3'd2);
        set_fix(32'h2000, 3'd3); drive(1, "e", 0, 1, 3'd1, 3'd2);
        set_fix(32'h4000, 3'd3); drive(1, "f", 0, 1, 3'd1, 3'd2);

        set_fix(32'h54, 3'd3);    drive(1, "T", 0, 1, 3'd7, 3'd2);
        drive(1, "x", 1, 1, 3'd1, 3'd2);
        set_fix(32'h10000, 3'd4); drive(1, "g", 0, 1, 3'd1, 3'd2);
        set_fix(32'h20000, 3'd4); drive(1, "h", 0, 1, 3'd1, 3'd2);
        set_fix(32'h80000, 3'd5); drive(1, "i", 0, 1, 3'd1, 3'd2);
        idle(3);

        drive(1, "m", 0, 1, 3'd1, 3'd2);
        do_reset();
        set_fix(32'h80, 3'd1); drive(1, "a", 0, 1, 3'd1, 3'd2);
        idle(3);

        do_reset();
        for (int d = 0; d < 256; d++)
            for (int a = 0; a < 7; a++)
                drive(1, 8'(d), 0, 1, 3'(a), 3'd0);
        idle(3);

        for (int i = 0; i < 2500; i++) begin
            logic [7:0] d;
            logic [2:0] rf;
            case ($urandom_range(0, 3))
                0: d = 8'(65 + $urandom_range(0, 25));
                1: d = 8'(97 + $urandom_range(0, 25));
                default: d = 8'($urandom_range(0, 255));
            endcase
            rf = ($urandom_range(0, 49) == 0) ? 3'($urandom_range(0, 7)) : bif.rot_freq;
            if ($urandom_range(0, 399) == 0)
                do_reset();
            drive($urandom_range(0, 3) != 0, d, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 7) != 0, 3'($urandom_range(0, 7)), rf);
        end
        idle(4);
        check_val("drain", q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
